// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin arbiter sharing one async-FIFO write port among
//                N write-domain requesters, with bounded bursts and an idle
//                timeout that revokes a stalled grant.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 8
) (
  input  logic                 clk,
  input  logic                 rst,           // asynchronous, active low
  input  logic [N-1:0]         req_valid,
  input  logic [N*DW-1:0]      req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ready,
  input  logic                 fifo_full,
  output logic                 fifo_wr_en,
  output logic [DW-1:0]        fifo_wr_data,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy
);

  localparam int GW = $clog2(N);
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]   idle_cnt_q, idle_cnt_d;
  logic            busy_q;

  logic [GW-1:0]   sel_idx;
  logic [GW-1:0]   cand;
  logic            any_req;
  logic            g_valid;
  logic            g_last;
  logic [DW-1:0]   g_data;
  logic            beat;
  logic            release_grant;

  // Round-robin pick: first valid requester after the last grantee, wrapping.
  // Scanning offsets downward lets the smallest offset overwrite the rest.
  always_comb begin
    any_req = |req_valid;
    sel_idx = last_q;
    cand    = last_q;
    for (int k = N; k >= 1; k--) begin
      cand = last_q + GW'(k);
      if (req_valid[cand]) begin
        sel_idx = cand;
      end
    end
  end

  // Select the granted requester's handshake and data, and qualify the beat.
  always_comb begin
    g_valid = req_valid[grant_q];
    g_last  = req_last[grant_q];
    g_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q == GW'(i)) begin
        g_data = req_data[i*DW +: DW];
      end
    end
    beat          = (state_q == S_GRANT) && g_valid && !fifo_full;
    release_grant = (beat && (g_last || (beat_cnt_q == CW'(MAX_BURST - 1)))) ||
                    ((state_q == S_GRANT) && !g_valid &&
                     (idle_cnt_q == TW'(TIMEOUT - 1)));
  end

  // Zero-latency write port; only the grantee ever sees ready.
  always_comb begin
    req_ready          = '0;
    req_ready[grant_q] = beat;
    fifo_wr_en         = beat;
    fifo_wr_data       = beat ? g_data : '0;
  end

  // Next-state logic: arbitrate in IDLE, count beats and idle cycles in GRANT.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d    = S_GRANT;
          grant_d    = sel_idx;
          last_d     = sel_idx;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end
      S_GRANT: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
        end
        // A full FIFO with valid held high is a stall, not idleness.
        if (g_valid) begin
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + TW'(1);
        end
        if (release_grant) begin
          state_d    = S_IDLE;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers; last_q resets to N-1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      last_q     <= GW'(N - 1);
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      busy_q     <= (state_d == S_GRANT);
    end
  end

  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule

`default_nettype wire
